// File: rtl/io_pkg.sv
// Shared constants for the interrupt-responder peripheral: register map,
// CTRL/STATUS bit positions and the handshake FSM encoding.
package io_pkg;

    // Word offsets inside the 16-byte register window (addr[3:2]).
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bits. SW_EVT is a write-only strobe and is never stored.
    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_INT_EN   = 1;
    localparam int CTRL_SW_EVT   = 2;

    // STATUS bits.
    localparam int STAT_PENDING   = 0;
    localparam int STAT_OVERFLOW  = 1;
    localparam int STAT_CNT_LSB   = 4;
    localparam int STAT_STATE_LSB = 8;

    // Interrupt handshake states; the code is visible in STATUS[10:8].
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ACK  = 3'd2
    } state_e;

endpackage

// File: rtl/io_reload_timer.sv
// Free-running reload timer: counts RELOAD down to zero, emits a one-cycle
// event and reloads, giving one event every RELOAD+1 cycles while enabled.
module io_reload_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_en,
    input  logic [31:0] reload,
    output logic        event_pulse
);

    logic [31:0] tcnt;
    logic        armed;

    // A zero reload value disables events even when the timer is enabled.
    assign armed       = timer_en && (reload != 32'd0);
    assign event_pulse = armed && (tcnt == 32'd0);

    // Down-counter: track RELOAD while idle, reload on expiry, else decrement.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (!armed || event_pulse) begin
            tcnt <= reload;
        end else begin
            tcnt <= tcnt - 32'd1;
        end
    end

endmodule

// File: rtl/io_intr_responder.sv
// Memory-mapped interrupt responder: a 4-register window on the CPU data bus,
// a saturating pending-event counter fed by a reload timer and software
// strobes, and the intr/int_ack handshake FSM that services those events.
module io_intr_responder
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dm_cs,
    input  logic        dm_wr,
    input  logic        dm_rd,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        int_ack,
    output logic [31:0] DY,
    output logic        intr
);

    localparam logic [CNT_W+1:0] CNT_MAX_EXT = {2'b00, {CNT_W{1'b1}}};

    logic [31:0]      data_q;
    logic [31:0]      reload_q;
    logic [1:0]       ctrl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    state_e           state_q;
    state_e           state_d;

    logic             hit;
    logic [1:0]       sel;
    logic             wr_en;
    logic             rd_en;
    logic             sw_evt;
    logic             tmr_evt;
    logic             service_done;
    logic [1:0]       inc;
    logic [CNT_W+1:0] cnt_sum;
    logic             cnt_sat;
    logic [31:0]      status;
    logic             unused_addr_bits;

    // Byte lanes are not decoded; the whole window is word-accessed.
    assign unused_addr_bits = ^addr[1:0];

    assign hit    = dm_cs && (addr[31:4] == BASE_ADDR[31:4]);
    assign sel    = addr[3:2];
    assign wr_en  = hit && dm_wr;
    assign rd_en  = reset && hit && dm_rd;
    assign sw_evt = wr_en && (sel == REG_CTRL) && din[CTRL_SW_EVT];

    io_reload_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .timer_en   (ctrl_q[CTRL_TIMER_EN]),
        .reload     (reload_q),
        .event_pulse(tmr_evt)
    );

    // Net counter change: up to two events in, at most one service out.
    assign inc     = {1'b0, tmr_evt} + {1'b0, sw_evt};
    assign cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, inc}
                   - {{(CNT_W + 1){1'b0}}, service_done};
    assign cnt_sat = (cnt_sum > CNT_MAX_EXT);

    // Software-visible registers; SW_EVT is a strobe and is not stored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q   <= '0;
            reload_q <= '0;
            ctrl_q   <= '0;
        end else if (wr_en) begin
            case (sel)
                REG_DATA:   data_q   <= din;
                REG_RELOAD: reload_q <= din;
                REG_CTRL:   ctrl_q   <= din[1:0];
                default:    ;
            endcase
        end
    end

    // Pending-event counter with saturation; overflow is sticky and W1C,
    // with a fresh overflow winning over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_sat ? CNT_MAX_EXT[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
            if (cnt_sat) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (sel == REG_STATUS) && din[STAT_OVERFLOW]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake next-state and Moore outputs; service completes when the
    // CPU releases int_ack, and only an unacknowledged request can be withdrawn.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        intr         = 1'b0;
        service_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_INT_EN] && (cnt_q != '0)) state_d = ST_REQ;
            end
            ST_REQ: begin
                intr = 1'b1;
                if (!ctrl_q[CTRL_INT_EN]) state_d = ST_IDLE;
                else if (int_ack)         state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!int_ack) begin
                    service_done = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // STATUS image assembled from live state.
    always_comb begin
        status                               = '0;
        status[STAT_PENDING]                 = (cnt_q != '0);
        status[STAT_OVERFLOW]                = ovf_q;
        status[STAT_CNT_LSB +: CNT_W]        = cnt_q;
        status[STAT_STATE_LSB +: 3]          = state_q;
    end

    // Combinational read port; zero whenever not selected or held in reset.
    always_comb begin
        DY = '0;
        if (rd_en) begin
            case (sel)
                REG_DATA:   DY = data_q;
                REG_RELOAD: DY = reload_q;
                REG_CTRL:   DY = {30'd0, ctrl_q};
                default:    DY = status;
            endcase
        end
    end

endmodule

// File: doc/io_intr_responder.md
Name: io_intr_responder

Overview:
- Memory-mapped I/O peripheral on the far side of the CPU data bus: decodes dm_cs/dm_wr/dm_rd at ALU_OUT addresses and returns read data on DY.
- Owns the CPU interrupt line: raises intr, completes the intr/int_ack handshake, and counts pending events from an internal reload timer or software triggers.
- Sits beside data memory in the top-level test system; its DY is muxed with data-memory DY by address.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base byte address of the 16-byte register window.
- CNT_W, 4, width of the pending-event counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- dm_cs  in  1  bus chip select from CPU.
- dm_wr  in  1  write strobe.
- dm_rd  in  1  read strobe.
- addr  in  32  byte address (CPU ALU_OUT).
- din  in  32  write data (CPU D_OUT).
- int_ack  in  1  interrupt acknowledge from CPU.
- DY  out  32  read data to CPU.
- intr  out  1  interrupt request to CPU.

Behaviour:
- Hit = dm_cs & (addr[31:4] == BASE_ADDR[31:4]); register select = addr[3:2]. addr[1:0] ignored.
- Registers:
  - 0 DATA: RW, 32 bits, scratch.
  - 1 RELOAD: RW, 32 bits.
  - 2 CTRL: RW bits [1:0]; bit0 = timer_en, bit1 = int_en. Writing 1 to bit2 gives a one-shot software event; bit2 is not stored and reads 0.
  - 3 STATUS: RO except W1C bit1.
    - [0] = pending (cnt != 0).
    - [1] = overflow (sticky).
    - [4+CNT_W-1:4] = cnt.
    - [10:8] = FSM state code.
- Write: hit & dm_wr, updates on the clock edge. Read: combinational; DY = selected register when hit & dm_rd, else 32'h0. dm_wr and dm_rd both high: write takes effect, read returns the old value.
- Timer: 32-bit down-counter TCNT.
  - timer_en = 0: TCNT loads RELOAD each cycle.
  - timer_en = 1 and RELOAD != 0: TCNT decrements each cycle. At TCNT == 0 it raises a timer event and reloads RELOAD, giving period RELOAD+1 cycles.
  - RELOAD == 0: no timer events.
- Event counter cnt:
  - +1 per event (timer or software; both in one cycle count as +2).
  - -1 on service completion.
  - Increment and decrement in the same cycle: net change applies.
  - Saturates at max; each dropped event sets overflow.
- FSM states:
  - IDLE(0): intr = 0. Go to REQ when int_en & cnt != 0.
  - REQ(1): intr = 1. Go to ACK when int_ack = 1.
  - ACK(2): intr = 0. Wait for int_ack = 0, then decrement cnt and return to IDLE.
- int_ack in IDLE is ignored.
- Clearing int_en while in REQ drops intr and returns to IDLE with cnt unchanged. Clearing int_en in ACK does not abort the handshake.
- Reset (reset == 0 on a clock edge), including mid-handshake:
  - All registers clear, TCNT = 0, cnt = 0, overflow = 0, state = IDLE.
  - intr = 0 from the next edge. DY = 0 while reset is held, regardless of strobes.
- Latency: an event at edge N makes intr = 1 after edge N+1 (IDLE→REQ), provided int_en = 1.

Decomposition:
- Shared package io_pkg: register offset constants (DATA = 0, RELOAD = 1, CTRL = 2, STATUS = 3), CTRL/STATUS bit-position constants, FSM state encoding.
- One natural sub-module, io_reload_timer: RELOAD/enable inputs, event pulse output.
- Register file, counter and FSM stay in the top.

Test Plan:
- Reset then read all four registers → DY = 0 for each; intr = 0.
- Write 32'hDEADBEEF to BASE_ADDR+0, read back → 32'hDEADBEEF. Read BASE_ADDR+16 (miss) → DY = 0.
- RELOAD = 4, CTRL = 3'b011 → intr rises 1 cycle after the first event at cycle 5. Pulse int_ack high 2 cycles then low → intr drops on ack; STATUS cnt decrements.
- int_en = 0, RELOAD = 1, timer_en = 1, run 40 cycles → cnt = 15 and STATUS[1] = 1. Write STATUS 32'h2 → overflow clears, cnt stays 15.
- Software trigger (write CTRL 3'b110) on the same cycle the FSM completes ACK→IDLE → cnt unchanged net; intr re-asserts next cycle.
- Assert reset (low) while in REQ with cnt = 3 → next edge intr = 0, cnt = 0, state = IDLE; no intr after release until a new event occurs.
